// File: rtl/addsub_accum_if.sv
// Operand/result handshake bundle for addsub_accum: valid/ready on the operand
// side, valid/ready plus status on the result side.
interface addsub_accum_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf_sticky;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid, op_a, op_b, mode, out_ready,
    input  in_ready, out_valid, result, carry, ovf_sticky, count
  );

  modport slave (
    input  in_valid, op_a, op_b, mode, out_ready,
    output in_ready, out_valid, result, carry, ovf_sticky, count
  );

endinterface

// File: rtl/addsub_accum.sv
// Registered add/subtract/accumulate unit with optional unsigned saturation,
// sticky overflow, saturating op counter and valid/ready on both sides.
module addsub_accum #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            clr,
  addsub_accum_if.slave   bus
);

  logic             w_accept;
  logic             w_clr;
  logic             w_isAcc;
  logic             w_isSub;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_operand;
  logic [WIDTH:0]   w_wide;
  logic             w_carry;
  logic [WIDTH-1:0] w_final;
  logic [WIDTH-1:0] w_accNext;
  logic [CNT_W-1:0] w_countBase;
  logic [CNT_W-1:0] w_countNext;
  logic             w_ovfNext;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_carry;
  logic             r_outValid;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;

  assign bus.in_ready   = ena & (~r_outValid | bus.out_ready);
  assign w_accept       = bus.in_valid & bus.in_ready;
  assign w_clr          = ena & clr;
  assign w_isAcc        = bus.mode[1];
  assign w_isSub        = bus.mode[0];

  assign bus.out_valid  = r_outValid;
  assign bus.result     = r_result;
  assign bus.carry      = r_carry;
  assign bus.ovf_sticky = r_ovf;
  assign bus.count      = r_count;

  // A clear in the same cycle as an accumulate op means the op starts from zero.
  always_comb begin
    w_base    = bus.op_a;
    w_operand = bus.op_b;
    if (w_isAcc) begin
      w_base    = w_clr ? '0 : r_acc;
      w_operand = bus.op_a;
    end
    if (w_isSub) begin
      w_wide = {1'b0, w_base} - {1'b0, w_operand};
    end else begin
      w_wide = {1'b0, w_base} + {1'b0, w_operand};
    end
    w_carry = w_wide[WIDTH];
    w_final = w_wide[WIDTH-1:0];
    if (SATURATE && w_carry) begin
      w_final = w_isSub ? '0 : '1;
    end
  end

  always_comb begin
    w_accNext = w_clr ? '0 : r_acc;
    if (w_accept && w_isAcc) begin
      w_accNext = w_final;
    end
    w_countBase = w_clr ? '0 : r_count;
    w_countNext = w_countBase;
    if (w_accept && (w_countBase != '1)) begin
      w_countNext = w_countBase + CNT_W'(1);
    end
    w_ovfNext = (w_clr ? 1'b0 : r_ovf) | (w_accept & w_carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_result   <= '0;
      r_carry    <= 1'b0;
      r_outValid <= 1'b0;
      r_ovf      <= 1'b0;
      r_count    <= '0;
    end else begin
      r_acc   <= w_accNext;
      r_count <= w_countNext;
      r_ovf   <= w_ovfNext;
      if (w_accept) begin
        r_result   <= w_final;
        r_carry    <= w_carry;
        r_outValid <= 1'b1;
      end else if (bus.out_ready) begin
        r_outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addsub_accum.sv
// Directed bench for addsub_accum: one saturating and one wrapping instance
// driven in lockstep, checked against hand-computed vectors and sequences.
module tb_addsub_accum;

  typedef struct {
    logic       ena;
    logic       clr;
    logic       valid;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       outReady;
    logic       expReady;
    logic       expValid;
    logic [7:0] satRes;
    logic       satCarry;
    logic [7:0] wrapRes;
    logic       wrapCarry;
    logic       expOvf;
    logic [3:0] expCount;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       tEna;
  logic       tClr;
  logic       tValid;
  logic [1:0] tMode;
  logic [7:0] tA;
  logic [7:0] tB;
  logic       tOutReady;

  int nVec;
  int nMiss;

  addsub_accum_if #(.WIDTH(8), .CNT_W(4)) ifS ();
  addsub_accum_if #(.WIDTH(8), .CNT_W(4)) ifW ();

  assign ifS.in_valid  = tValid;
  assign ifS.op_a      = tA;
  assign ifS.op_b      = tB;
  assign ifS.mode      = tMode;
  assign ifS.out_ready = tOutReady;
  assign ifW.in_valid  = tValid;
  assign ifW.op_a      = tA;
  assign ifW.op_b      = tB;
  assign ifW.mode      = tMode;
  assign ifW.out_ready = tOutReady;

  addsub_accum #(.WIDTH(8), .SATURATE(1'b1), .CNT_W(4)) uSat (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (tEna),
    .clr   (tClr),
    .bus   (ifS.slave)
  );

  addsub_accum #(.WIDTH(8), .SATURATE(1'b0), .CNT_W(4)) uWrap (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (tEna),
    .clr   (tClr),
    .bus   (ifW.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic setInputs(input logic ena, input logic clr, input logic valid,
                           input logic [1:0] mode, input logic [7:0] a,
                           input logic [7:0] b, input logic outReady);
    tEna      = ena;
    tClr      = clr;
    tValid    = valid;
    tMode     = mode;
    tA        = a;
    tB        = b;
    tOutReady = outReady;
  endtask

  // Inputs are driven 1ns after a rising edge; outputs are sampled 1ns after the next.
  task automatic applyStimulus(input vec_t v, input int idx);
    setInputs(v.ena, v.clr, v.valid, v.mode, v.a, v.b, v.outReady);
    #1;
    checkOutput("in_ready", idx, 32'(ifS.in_ready), 32'(v.expReady));
    @(posedge clk);
    #1;
    checkOutput("out_valid", idx, 32'(ifS.out_valid), 32'(v.expValid));
    checkOutput("sat_result", idx, 32'(ifS.result), 32'(v.satRes));
    checkOutput("sat_carry", idx, 32'(ifS.carry), 32'(v.satCarry));
    checkOutput("wrap_result", idx, 32'(ifW.result), 32'(v.wrapRes));
    checkOutput("wrap_carry", idx, 32'(ifW.carry), 32'(v.wrapCarry));
    checkOutput("ovf_sticky", idx, 32'(ifS.ovf_sticky), 32'(v.expOvf));
    checkOutput("count", idx, 32'(ifS.count), 32'(v.expCount));
    checkOutput("wrap_count", idx, 32'(ifW.count), 32'(v.expCount));
  endtask

  vec_t vecs[15];
  int   cnt;

  initial begin
    nVec  = 0;
    nMiss = 0;

    //           ena   clr   vld   mode   a     b     ordy  rdy   oval  satR  satC  wrR   wrC   ovf   cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'b00, 8'd200, 8'd100, 1'b1, 1'b1, 1'b1, 8'd255, 1'b1, 8'd44,  1'b1, 1'b1, 4'd1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'b00, 8'd0,   8'd0,   1'b1, 1'b1, 1'b0, 8'd255, 1'b1, 8'd44,  1'b1, 1'b0, 4'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'b10, 8'd10,  8'd0,   1'b1, 1'b1, 1'b1, 8'd10,  1'b0, 8'd10,  1'b0, 1'b0, 4'd1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'b10, 8'd10,  8'd0,   1'b1, 1'b1, 1'b1, 8'd20,  1'b0, 8'd20,  1'b0, 1'b0, 4'd2};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 2'b10, 8'd10,  8'd0,   1'b1, 1'b1, 1'b1, 8'd30,  1'b0, 8'd30,  1'b0, 1'b0, 4'd3};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'b01, 8'd5,   8'd9,   1'b1, 1'b1, 1'b1, 8'd0,   1'b1, 8'd252, 1'b1, 1'b1, 4'd4};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 2'b00, 8'd3,   8'd4,   1'b1, 1'b1, 1'b1, 8'd7,   1'b0, 8'd7,   1'b0, 1'b1, 4'd5};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 2'b11, 8'd30,  8'd0,   1'b1, 1'b1, 1'b1, 8'd0,   1'b0, 8'd0,   1'b0, 1'b1, 4'd6};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'b11, 8'd7,   8'd0,   1'b1, 1'b1, 1'b1, 8'd0,   1'b1, 8'd249, 1'b1, 1'b1, 4'd7};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 2'b10, 8'd5,   8'd0,   1'b1, 1'b1, 1'b1, 8'd5,   1'b0, 8'd254, 1'b0, 1'b1, 4'd8};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 2'b11, 8'd7,   8'd0,   1'b1, 1'b1, 1'b1, 8'd0,   1'b1, 8'd247, 1'b0, 1'b1, 4'd9};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 2'b10, 8'd3,   8'd0,   1'b1, 1'b1, 1'b1, 8'd3,   1'b0, 8'd3,   1'b0, 1'b0, 4'd1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 2'b00, 8'd1,   8'd1,   1'b1, 1'b0, 1'b0, 8'd3,   1'b0, 8'd3,   1'b0, 1'b0, 4'd1};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 2'b00, 8'd255, 8'd1,   1'b1, 1'b1, 1'b1, 8'd255, 1'b1, 8'd0,   1'b1, 1'b1, 4'd1};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 2'b10, 8'd0,   8'd0,   1'b1, 1'b1, 1'b1, 8'd0,   1'b0, 8'd0,   1'b0, 1'b1, 4'd2};

    rst_n = 1'b0;
    setInputs(1'b1, 1'b0, 1'b0, 2'b00, 8'd0, 8'd0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 0, 32'(ifS.out_valid), 32'd0);
    checkOutput("rst_result", 0, 32'(ifS.result), 32'd0);
    checkOutput("rst_carry", 0, 32'(ifS.carry), 32'd0);
    checkOutput("rst_ovf", 0, 32'(ifS.ovf_sticky), 32'd0);
    checkOutput("rst_count", 0, 32'(ifS.count), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", 0, 32'(ifS.in_ready), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Result 0 is pending; hold it for five cycles against a waiting producer.
    setInputs(1'b1, 1'b0, 1'b1, 2'b00, 8'd1, 8'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp_in_ready", i, 32'(ifS.in_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", i, 32'(ifS.out_valid), 32'd1);
      checkOutput("bp_result", i, 32'(ifS.result), 32'd0);
      checkOutput("bp_count", i, 32'(ifS.count), 32'd2);
    end
    tOutReady = 1'b1;
    #1;
    checkOutput("bp_release_ready", 0, 32'(ifS.in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("bp_new_result", 0, 32'(ifS.result), 32'd3);
    checkOutput("bp_new_valid", 0, 32'(ifS.out_valid), 32'd1);
    checkOutput("bp_new_count", 0, 32'(ifS.count), 32'd3);

    cnt = 3;
    for (int i = 0; i < 20; i++) begin
      setInputs(1'b1, 1'b0, 1'b1, 2'b00, 8'(i), 8'd1, 1'b1);
      @(posedge clk);
      #1;
      if (cnt < 15) cnt++;
      checkOutput("run_result", i, 32'(ifS.result), 32'(i + 1));
      checkOutput("run_count", i, 32'(ifS.count), 32'(cnt));
    end
    checkOutput("run_count_final", 0, 32'(ifW.count), 32'd15);
    checkOutput("run_ovf", 0, 32'(ifS.ovf_sticky), 32'd1);

    // Asynchronous reset between edges must clear outputs without a clock.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_result", 0, 32'(ifS.result), 32'd0);
    checkOutput("arst_out_valid", 0, 32'(ifS.out_valid), 32'd0);
    checkOutput("arst_count", 0, 32'(ifS.count), 32'd0);
    checkOutput("arst_ovf", 0, 32'(ifS.ovf_sticky), 32'd0);
    checkOutput("arst_wrap_result", 0, 32'(ifW.result), 32'd0);
    checkOutput("arst_wrap_count", 0, 32'(ifW.count), 32'd0);
    tValid = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("arst_in_ready", 0, 32'(ifS.in_ready), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("arst_idle_valid", 0, 32'(ifS.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
